// File: rtl/ftdi_tx_scheduler_pkg.sv
// Shared constants for the FT600 245-sync write-side scheduler and its arbiter.
// The read-side controller is expected to reuse the state and grant encodings.
package ftdi_tx_scheduler_pkg;

  localparam int FT_DATA_W = 32;
  localparam int FT_BE_W   = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARB  = 2'd1;
  localparam logic [1:0] ST_XFER = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

  typedef logic [1:0] grant_t;

  localparam grant_t GRANT_NONE = 2'b00;
  localparam grant_t GRANT_REQ0 = 2'b01;
  localparam grant_t GRANT_REQ1 = 2'b10;

endpackage

// File: rtl/ftdi_tx_scheduler_rr_arbiter_2.sv
// Two-way round-robin arbiter: combinational grant, last_grant advanced only when
// the scheduler commits a grant in ARB.
module rr_arbiter_2
  import ftdi_tx_scheduler_pkg::*;
(
  input  logic   clk_in,
  input  logic   rst_in,
  input  logic   [1:0] req,
  input  logic   advance,
  output grant_t grant
);

  grant_t last_grant;

  always_comb begin
    grant = GRANT_NONE;
    if (req == 2'b11) begin
      grant = (last_grant == GRANT_REQ0) ? GRANT_REQ1 : GRANT_REQ0;
    end else if (req[0]) begin
      grant = GRANT_REQ0;
    end else if (req[1]) begin
      grant = GRANT_REQ1;
    end
  end

  // Reset to req1 so that req0 wins the first contended grant.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      last_grant <= GRANT_REQ1;
    end else if (advance && (grant != GRANT_NONE)) begin
      last_grant <= grant;
    end
  end

endmodule

// File: rtl/ftdi_tx_scheduler.sv
// FT600 245-sync write scheduler: shares DATA/BE/WR_N between a bulk FIFO (req0)
// and a status FIFO (req1) with round-robin, length-bounded bursts.
//   state | meaning
//   IDLE  | bus released, wait for TXE_N low and a non-empty request
//   ARB   | pick owner, pop its head into data_out, drive the bus
//   XFER  | present held word; on acceptance load the next one back-to-back
//   GAP   | bus released for GAP_CYC cycles before the next arbitration
module ftdi_tx_scheduler
  import ftdi_tx_scheduler_pkg::*;
#(
  parameter int DATA_W    = FT_DATA_W,
  parameter int BE_W      = FT_BE_W,
  parameter int BURST_MAX = 256,
  parameter int GAP_CYC   = 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [DATA_W-1:0] req0_data_in,
  input  logic              req0_empty_in,
  output logic              req0_rd_en_out,
  input  logic [DATA_W-1:0] req1_data_in,
  input  logic              req1_empty_in,
  output logic              req1_rd_en_out,
  input  logic              txe_n_in,
  output logic [DATA_W-1:0] data_out,
  output logic [BE_W-1:0]   be_out,
  output logic              data_oe_out,
  output logic              wr_n_out,
  output logic [1:0]        grant_out,
  output logic [15:0]       words_out
);

  localparam int CNT_W = $clog2(BURST_MAX + 1);
  localparam int GAP_W = $clog2(GAP_CYC + 1);
  localparam logic [CNT_W-1:0] BURST_CNT = CNT_W'(BURST_MAX);

  logic [1:0]        state;
  logic [CNT_W-1:0]  burst_cnt;
  logic [CNT_W-1:0]  burst_inc;
  logic [GAP_W-1:0]  gap_cnt;
  grant_t            arb_grant;
  grant_t            pop;
  logic              accept;
  logic              owner_empty;
  logic              load_next;
  logic [DATA_W-1:0] pop_data;

  rr_arbiter_2 u_arb (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .req     ({~req1_empty_in, ~req0_empty_in}),
    .advance (state == ST_ARB),
    .grant   (arb_grant)
  );

  assign accept      = (state == ST_XFER) && !wr_n_out && !txe_n_in;
  assign owner_empty = grant_out[1] ? req1_empty_in : (grant_out[0] ? req0_empty_in : 1'b1);
  assign burst_inc   = burst_cnt + 1'b1;
  assign load_next   = accept && (burst_inc < BURST_CNT) && !owner_empty;

  // A FIFO is popped only in the cycle its head is captured into data_out.
  assign pop            = (state == ST_ARB) ? arb_grant : (load_next ? grant_t'(grant_out) : GRANT_NONE);
  assign req0_rd_en_out = pop[0];
  assign req1_rd_en_out = pop[1];
  assign pop_data       = pop[1] ? req1_data_in : req0_data_in;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state       <= ST_IDLE;
      burst_cnt   <= '0;
      gap_cnt     <= '0;
      data_out    <= '0;
      be_out      <= '0;
      data_oe_out <= 1'b0;
      wr_n_out    <= 1'b1;
      grant_out   <= GRANT_NONE;
      words_out   <= '0;
    end else begin
      if (accept) begin
        words_out <= words_out + 16'd1;
      end
      case (state)
        ST_IDLE: begin
          if (!txe_n_in && (!req0_empty_in || !req1_empty_in)) begin
            state <= ST_ARB;
          end
        end
        ST_ARB: begin
          burst_cnt <= '0;
          if (arb_grant != GRANT_NONE) begin
            grant_out   <= arb_grant;
            data_out    <= pop_data;
            be_out      <= '1;
            data_oe_out <= 1'b1;
            wr_n_out    <= txe_n_in;
            state       <= ST_XFER;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_XFER: begin
          if (accept) begin
            burst_cnt <= burst_inc;
            if (load_next) begin
              data_out <= pop_data;
            end else begin
              wr_n_out    <= 1'b1;
              data_oe_out <= 1'b0;
              be_out      <= '0;
              grant_out   <= GRANT_NONE;
              gap_cnt     <= GAP_W'(GAP_CYC - 1);
              state       <= ST_GAP;
            end
          end else begin
            // Held word stays in data_out; WR_N follows TXE_N until it is taken.
            wr_n_out <= txe_n_in;
          end
        end
        ST_GAP: begin
          burst_cnt <= '0;
          if (gap_cnt == '0) begin
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
